// File: rtl/sample_hex_line_formatter_if.sv
// Sample stream into the hex line formatter and the byte-wide UART request/busy handshake.
// The formatter uses the slave view; the sensor logic and UART side use the master view.
interface sample_hex_line_formatter_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_ready;
    logic                  uart_send_enable;
    logic [7:0]            uart_send_data;
    logic                  uart_busy;

    modport master (
        output in_valid, in_data, uart_busy,
        input  in_ready, uart_send_enable, uart_send_data
    );

    modport slave (
        input  in_valid, in_data, uart_busy,
        output in_ready, uart_send_enable, uart_send_data
    );
endinterface

// File: rtl/sample_hex_line_formatter.sv
// Turns one sample per valid/ready handshake into an uppercase ASCII hex line (CR LF or LF) sent
// byte by byte over a UART enable/busy handshake. Define HEX_PREFIX_EN to start each line with "0x".
module sample_hex_line_formatter #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter bit          EOL_CR     = 1'b1
) (
    input logic                        clk,
    input logic                        rst,
    sample_hex_line_formatter_if.slave bus
);
    localparam int unsigned NIBBLES = DATA_WIDTH / 4;
    localparam int unsigned EOL_LEN = EOL_CR ? 2 : 1;
`ifdef HEX_PREFIX_EN
    localparam int unsigned PREFIX_LEN = 2;
`else
    localparam int unsigned PREFIX_LEN = 0;
`endif
    localparam int unsigned LINE_LEN = PREFIX_LEN + NIBBLES + EOL_LEN;
    localparam int unsigned IDX_W    = $clog2(LINE_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LINE_LEN - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StStart, StWait} state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                  enable_q, enable_d;
    logic [7:0]            data_q, data_d;

    logic [7:0]            cur_char;
    logic [3:0]            nib;
    int unsigned           pos;
    int unsigned           digit;

    // Character for the current index: [prefix] nibbles MSB first, then terminator.
    always_comb begin
        pos      = 32'(idx_q);
        digit    = 0;
        nib      = 4'h0;
        cur_char = 8'h0A;
`ifdef HEX_PREFIX_EN
        if (pos < PREFIX_LEN) begin
            cur_char = (pos == 0) ? 8'h30 : 8'h78;
        end else
`endif
        if (pos < PREFIX_LEN + NIBBLES) begin
            digit    = pos - PREFIX_LEN;
            nib      = 4'(sample_q >> (4 * (NIBBLES - 1 - digit)));
            cur_char = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
        end else if (EOL_CR && (pos == PREFIX_LEN + NIBBLES)) begin
            cur_char = 8'h0D;
        end else begin
            cur_char = 8'h0A;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        sample_d = sample_q;
        enable_d = enable_q;
        data_d   = data_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sample_d = bus.in_data;
                    idx_d    = '0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                // A busy UART here belongs to someone else; wait it out before requesting.
                if (!bus.uart_busy) begin
                    data_d   = cur_char;
                    enable_d = 1'b1;
                    state_d  = StStart;
                end
            end
            StStart: begin
                if (bus.uart_busy) begin
                    enable_d = 1'b0;
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (!bus.uart_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            sample_q <= '0;
            enable_q <= 1'b0;
            data_q   <= 8'h00;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sample_q <= sample_d;
            enable_q <= enable_d;
            data_q   <= data_d;
        end
    end

    assign bus.in_ready         = (state_q == StIdle) && !rst;
    assign bus.uart_send_enable = enable_q;
    assign bus.uart_send_data   = data_q;
endmodule

// File: tb/tb_sample_hex_line_formatter.sv
// Directed bench for sample_hex_line_formatter: three instances (16b CR LF, 8b CR LF, 8b LF)
// each driving a simple busy-for-N-cycles UART model that records the bytes it accepts.
module tb_sample_hex_line_formatter;
    localparam int LIMIT  = 5000;
    localparam int BUSY_A = 40;
    localparam int BUSY_B = 3;
    localparam int BUSY_C = 3;

    typedef logic [7:0] bq_t[$];
    typedef logic [7:0] line_t[6];
    typedef struct {
        int          sel;
        logic [15:0] data;
        int          n;
        line_t       b;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] hold = '0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sample_hex_line_formatter_if #(.DATA_WIDTH(16)) if_a ();
    sample_hex_line_formatter_if #(.DATA_WIDTH(8))  if_b ();
    sample_hex_line_formatter_if #(.DATA_WIDTH(8))  if_c ();

    sample_hex_line_formatter #(.DATA_WIDTH(16), .EOL_CR(1'b1)) u_a (.clk(clk), .rst(rst), .bus(if_a));
    sample_hex_line_formatter #(.DATA_WIDTH(8),  .EOL_CR(1'b1)) u_b (.clk(clk), .rst(rst), .bus(if_b));
    sample_hex_line_formatter #(.DATA_WIDTH(8),  .EOL_CR(1'b0)) u_c (.clk(clk), .rst(rst), .bus(if_c));

    // UART models: take a byte when enable is seen while idle, then stay busy. Not reset by rst,
    // so a byte in flight finishes on its own.
    int         cnt_a = 0, cnt_b = 0, cnt_c = 0;
    int         pul_a = 0, pul_b = 0, pul_c = 0;
    logic       pe_a = 1'b0, pe_b = 1'b0, pe_c = 1'b0;
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];

    assign if_a.uart_busy = (cnt_a != 0) || hold[0];
    assign if_b.uart_busy = (cnt_b != 0) || hold[1];
    assign if_c.uart_busy = (cnt_c != 0) || hold[2];

    always @(posedge clk) begin
        pe_a <= if_a.uart_send_enable;
        if (if_a.uart_send_enable && !pe_a) pul_a <= pul_a + 1;
        if (cnt_a != 0) cnt_a <= cnt_a - 1;
        else if (if_a.uart_send_enable && !hold[0]) begin
            cnt_a <= BUSY_A;
            qa.push_back(if_a.uart_send_data);
        end
    end

    always @(posedge clk) begin
        pe_b <= if_b.uart_send_enable;
        if (if_b.uart_send_enable && !pe_b) pul_b <= pul_b + 1;
        if (cnt_b != 0) cnt_b <= cnt_b - 1;
        else if (if_b.uart_send_enable && !hold[1]) begin
            cnt_b <= BUSY_B;
            qb.push_back(if_b.uart_send_data);
        end
    end

    always @(posedge clk) begin
        pe_c <= if_c.uart_send_enable;
        if (if_c.uart_send_enable && !pe_c) pul_c <= pul_c + 1;
        if (cnt_c != 0) cnt_c <= cnt_c - 1;
        else if (if_c.uart_send_enable && !hold[2]) begin
            cnt_c <= BUSY_C;
            qc.push_back(if_c.uart_send_data);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic rdy(input int s);
        case (s)
            0: return if_a.in_ready;
            1: return if_b.in_ready;
            default: return if_c.in_ready;
        endcase
    endfunction

    function automatic logic en(input int s);
        case (s)
            0: return if_a.uart_send_enable;
            1: return if_b.uart_send_enable;
            default: return if_c.uart_send_enable;
        endcase
    endfunction

    function automatic logic [7:0] dat(input int s);
        case (s)
            0: return if_a.uart_send_data;
            1: return if_b.uart_send_data;
            default: return if_c.uart_send_data;
        endcase
    endfunction

    function automatic int qsize(input int s);
        case (s)
            0: return qa.size();
            1: return qb.size();
            default: return qc.size();
        endcase
    endfunction

    function automatic int pulses(input int s);
        case (s)
            0: return pul_a;
            1: return pul_b;
            default: return pul_c;
        endcase
    endfunction

    function automatic logic [7:0] qbyte(input int s, input int i);
        if (i >= qsize(s)) return 8'hxx;
        case (s)
            0: return qa[i];
            1: return qb[i];
            default: return qc[i];
        endcase
    endfunction

    // Expected line for n table bytes, with the "0x" prefix when that build option is on.
    function automatic bq_t mk(input int n, input line_t b);
        bq_t q;
        q = {};
`ifdef HEX_PREFIX_EN
        q.push_back(8'h30);
        q.push_back(8'h78);
`endif
        for (int i = 0; i < n; i++) q.push_back(b[i]);
        return q;
    endfunction

    task automatic set_in(input int s, input logic v, input logic [15:0] d);
        case (s)
            0: begin if_a.in_valid = v; if_a.in_data = d; end
            1: begin if_b.in_valid = v; if_b.in_data = d[7:0]; end
            default: begin if_c.in_valid = v; if_c.in_data = d[7:0]; end
        endcase
    endtask

    // Present a sample, wait for acceptance, then scramble in_data to test the capture.
    task automatic send(input int s, input logic [15:0] d, input bit lat);
        int n;
        n = 0;
        @(negedge clk);
        set_in(s, 1'b1, d);
        while (!rdy(s) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("accept_wait%0d", s), 32'(n < LIMIT), 32'd1);
        @(negedge clk);
        set_in(s, 1'b0, ~d);
        if (lat) begin
            chk($sformatf("en_after_accept%0d", s), 32'(en(s)), 32'd0);
            @(negedge clk);
            chk($sformatf("en_second_edge%0d", s), 32'(en(s)), 32'd1);
        end
    endtask

    task automatic wait_idle(input int s);
        int n;
        n = 0;
        while (!rdy(s) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("line_wait%0d", s), 32'(n < LIMIT), 32'd1);
    endtask

    task automatic check_line(input string tag, input int s, input int base, input int pbase,
                              input bq_t exp);
        for (int i = 0; i < exp.size(); i++)
            chk($sformatf("%s byte%0d", tag, i), 32'(qbyte(s, base + i)), 32'(exp[i]));
        chk($sformatf("%s count", tag), 32'(qsize(s) - base), 32'(exp.size()));
        chk($sformatf("%s pulses", tag), 32'(pulses(s) - pbase), 32'(exp.size()));
    endtask

    initial begin
        vec_t  vecs[8];
        line_t l1, l2;
        bq_t   exp;
        int    base, pbase, n, viol;

        vecs[0] = '{0, 16'h01FF, 6, '{8'h30, 8'h31, 8'h46, 8'h46, 8'h0D, 8'h0A}};
        vecs[1] = '{0, 16'hABCD, 6, '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A}};
        vecs[2] = '{0, 16'h0000, 6, '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A}};
        vecs[3] = '{0, 16'h9A5F, 6, '{8'h39, 8'h41, 8'h35, 8'h46, 8'h0D, 8'h0A}};
        vecs[4] = '{1, 16'h00E5, 4, '{8'h45, 8'h35, 8'h0D, 8'h0A, 8'h00, 8'h00}};
        vecs[5] = '{1, 16'h0009, 4, '{8'h30, 8'h39, 8'h0D, 8'h0A, 8'h00, 8'h00}};
        vecs[6] = '{2, 16'h000F, 3, '{8'h30, 8'h46, 8'h0A, 8'h00, 8'h00, 8'h00}};
        vecs[7] = '{2, 16'h00A0, 3, '{8'h41, 8'h30, 8'h0A, 8'h00, 8'h00, 8'h00}};

        // Reset with in_valid asserted on instance a: nothing may be captured.
        set_in(0, 1'b1, 16'h5555);
        set_in(1, 1'b0, 16'h0000);
        set_in(2, 1'b0, 16'h0000);
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("rst_ready%0d", s), 32'(rdy(s)), 32'd0);
            chk($sformatf("rst_enable%0d", s), 32'(en(s)), 32'd0);
            chk($sformatf("rst_data%0d", s), 32'(dat(s)), 32'd0);
        end
        set_in(0, 1'b0, 16'h0000);
        rst = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) chk($sformatf("post_rst_ready%0d", s), 32'(rdy(s)), 32'd1);
        repeat (10) @(negedge clk);
        chk("rst_wins_no_bytes", 32'(qsize(0)), 32'd0);

        for (int v = 0; v < 8; v++) begin
            base  = qsize(vecs[v].sel);
            pbase = pulses(vecs[v].sel);
            send(vecs[v].sel, vecs[v].data, 1'b1);
            wait_idle(vecs[v].sel);
            check_line($sformatf("vec%0d", v), vecs[v].sel, base, pbase, mk(vecs[v].n, vecs[v].b));
        end

        // Backpressure: 0xABCD held valid mid-line, accepted only after the first line ends.
        base  = qsize(0);
        pbase = pulses(0);
        send(0, 16'h01FF, 1'b1);
        @(negedge clk);
        set_in(0, 1'b1, 16'hABCD);
        n = 0;
        while (!rdy(0) && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("bp_wait", 32'(n < LIMIT), 32'd1);
        l1 = '{8'h30, 8'h31, 8'h46, 8'h46, 8'h0D, 8'h0A};
        l2 = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h0D, 8'h0A};
        chk("bp_first_line_done", 32'(qsize(0) - base), 32'(mk(6, l1).size()));
        @(negedge clk);
        set_in(0, 1'b0, 16'h0000);
        wait_idle(0);
        repeat (20) @(negedge clk);
        exp = {mk(6, l1), mk(6, l2)};
        check_line("bp", 0, base, pbase, exp);

        // Reset after the second byte of 0x1234, then a clean 0x0000 line.
        base = qsize(0);
        send(0, 16'h1234, 1'b1);
        n = 0;
        while ((qsize(0) - base) < 2 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk("abort_wait", 32'(n < LIMIT), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_enable", 32'(en(0)), 32'd0);
        chk("abort_ready_in_rst", 32'(rdy(0)), 32'd0);
        rst = 1'b0;
        #1;
        chk("abort_ready", 32'(rdy(0)), 32'd1);
        base  = qsize(0);
        pbase = pulses(0);
        send(0, 16'h0000, 1'b0);
        wait_idle(0);
        l1 = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h0D, 8'h0A};
        check_line("after_abort", 0, base, pbase, mk(6, l1));

        // UART busy from another source for 100 cycles: must sit in LOAD with enable low.
        base  = qsize(0);
        pbase = pulses(0);
        hold[0] = 1'b1;
        send(0, 16'h01FF, 1'b0);
        viol = 0;
        repeat (100) begin
            @(negedge clk);
            if (en(0)) viol++;
        end
        chk("hold_enable_low", 32'(viol), 32'd0);
        chk("hold_no_bytes", 32'(qsize(0) - base), 32'd0);
        hold[0] = 1'b0;
        wait_idle(0);
        l1 = '{8'h30, 8'h31, 8'h46, 8'h46, 8'h0D, 8'h0A};
        check_line("hold", 0, base, pbase, mk(6, l1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
